ddfs_ctrl: RTL and testbench

DDFS_CTRL -- requirements
Module: ddfs_ctrl

---
 rtl/ddfs_pkg.sv | 25 ++
 rtl/ddfs_align_pipe.sv | 40 ++++
 rtl/ddfs_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ddfs_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_pkg.sv
// ddfs_pkg: shared types and constants for the DDFS phase controller.
//   ddfs_state_e : controller state (IDLE / RUN / DRAIN)
//   octant_t     : 3-bit octant index of the phase circle
//   LFSR_*       : 16-bit Galois LFSR (taps 16,14,13,11) used for optional
//                  phase dither (DDFS_DITHER_EN)
package ddfs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ddfs_state_e;

  typedef logic [2:0] octant_t;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One right-shift step of the Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/ddfs_align_pipe.sv
// ddfs_align_pipe: DEPTH-deep {valid, octant} delay line that lines up the
// octant index with the output of the first-octant core.
//   clk, rst (async, active-high)
//   valid_i / phi_i : sample entering the line
//   valid_o / phi_o : same sample, DEPTH cycles later
module ddfs_align_pipe
  import ddfs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    valid_i,
  input  octant_t phi_i,
  output logic    valid_o,
  output octant_t phi_o
);

  logic [DEPTH-1:0]    vld_q;
  octant_t [DEPTH-1:0] phi_q;

  // Shift register; reset flushes any in-flight samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      phi_q <= '0;
    end else begin
      vld_q[0] <= valid_i;
      phi_q[0] <= phi_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        phi_q[i] <= phi_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign phi_o   = phi_q[DEPTH-1];

endmodule

// File: rtl/ddfs_ctrl.sv
// ddfs_ctrl: phase accumulator, octant folding and tuning-word handshake
// for a first-octant DDFS core.
//   clk, rst (async, active-high), en : run request
//   ftw_valid/ftw_ready/ftw_data      : tuning-word handshake
//   core_phase/core_valid             : folded phase to the core
//   at_phi_r/at_valid                 : octant aligned with the core outputs
//   busy                              : controller not idle
// Optional: define DDFS_DITHER_EN to add LFSR dither below the rem LSB.
module ddfs_ctrl
  import ddfs_pkg::*;
#(
  parameter int unsigned PHASE_W  = 32,
  parameter int unsigned OCT_W    = 16,
  parameter int unsigned CORE_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] ftw_data,
  output logic [OCT_W-1:0]   core_phase,
  output logic               core_valid,
  output logic [2:0]         at_phi_r,
  output logic               at_valid,
  output logic               busy
);

  localparam int unsigned DITH_W = PHASE_W - 3 - OCT_W;
  localparam int unsigned TOP_W  = OCT_W + 3;
  localparam int unsigned CNT_W  = 4;

  ddfs_state_e        state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] ftw_q, ftw_d;
  logic [PHASE_W-1:0] pword_q, pword_d;
  logic               pend_q, pend_d;
  logic               ready_q, busy_q, core_valid_q;
  logic [OCT_W-1:0]   core_phase_q;
  octant_t            oct_q;

  logic               accept_c, wrap_c;
  logic [PHASE_W-1:0] acc_sum_c, dith_c;
  logic [TOP_W-1:0]   top_c;
  octant_t            oct_c;
  logic [OCT_W-1:0]   rem_c, fold_c;

`ifdef DDFS_DITHER_EN
  localparam logic [PHASE_W-1:0] DITH_MASK = (PHASE_W'(1) << DITH_W) - PHASE_W'(1);
  logic [LFSR_W-1:0] lfsr_q;

  // Dither source advances once per produced sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    lfsr_q <= LFSR_SEED;
    else if (state_q == ST_RUN) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign dith_c = PHASE_W'(lfsr_q) & DITH_MASK;
`else
  assign dith_c = '0;
`endif

  // Carry out of the accumulator add marks a phase wrap.
  assign {wrap_c, acc_sum_c} = {1'b0, acc_q} + {1'b0, ftw_q};
  assign accept_c = ftw_valid && ready_q;

  // Keep only octant+rem of the (optionally dithered) phase.
  assign top_c  = TOP_W'((acc_q + dith_c) >> DITH_W);
  assign oct_c  = top_c[TOP_W-1 -: 3];
  assign rem_c  = top_c[OCT_W-1:0];
  assign fold_c = oct_c[0] ? ~rem_c : rem_c;

  // State transitions; drain counter runs only inside DRAIN.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (drain_cnt_q == CNT_W'(CORE_LAT - 1)) begin
          state_d = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator and tuning-word bookkeeping. Outside IDLE a new word only
  // takes effect on a wrap (phase-continuous) or when falling back to IDLE.
  always_comb begin
    acc_d   = acc_q;
    ftw_d   = ftw_q;
    pend_d  = pend_q;
    pword_d = pword_q;
    if (state_q == ST_RUN) acc_d = acc_sum_c;
    if (state_q == ST_IDLE) begin
      if (pend_q) begin
        ftw_d  = pword_q;
        pend_d = 1'b0;
      end else if (accept_c) begin
        ftw_d = ftw_data;
      end
    end else begin
      if (pend_q && (((state_q == ST_RUN) && wrap_c) || (state_d == ST_IDLE))) begin
        ftw_d  = pword_q;
        pend_d = 1'b0;
      end
      if (accept_c) begin
        pword_d = ftw_data;
        pend_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      drain_cnt_q  <= '0;
      acc_q        <= '0;
      ftw_q        <= '0;
      pword_q      <= '0;
      pend_q       <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      core_valid_q <= 1'b0;
      core_phase_q <= '0;
      oct_q        <= '0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      pword_q      <= pword_d;
      pend_q       <= pend_d;
      ready_q      <= !pend_d;
      busy_q       <= (state_d != ST_IDLE);
      core_valid_q <= (state_q == ST_RUN);
      if (state_q == ST_RUN) begin
        core_phase_q <= fold_c;
        oct_q        <= oct_c;
      end
    end
  end

  ddfs_align_pipe #(
    .DEPTH (CORE_LAT)
  ) u_align (
    .clk     (clk),
    .rst     (rst),
    .valid_i (core_valid_q),
    .phi_i   (oct_q),
    .valid_o (at_valid),
    .phi_o   (at_phi_r)
  );

  assign ftw_ready  = ready_q;
  assign busy       = busy_q;
  assign core_valid = core_valid_q;
  assign core_phase = core_phase_q;

endmodule

// File: tb/tb_ddfs_ctrl.sv
// tb_ddfs_ctrl: self-checking bench for ddfs_ctrl (default parameters).
// A cycle-level behavioural model predicts every output; a few literal
// expectations pin the model. Honours DDFS_DITHER_EN like the design.
module tb_ddfs_ctrl;

  localparam int PW = 32;
  localparam int OW = 16;
  localparam int CL = 4;
  localparam int DW = PW - 3 - OW;
  localparam longint unsigned MOD = 64'd1 << PW;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst, en, ftw_valid;
  logic [PW-1:0] ftw_data;
  logic          ftw_ready, core_valid, at_valid, busy;
  logic [OW-1:0] core_phase;
  logic [2:0]    at_phi_r;

  int tests = 0;
  int fails = 0;

  // model state
  int               m_mode, m_drain_left;
  longint unsigned  m_acc, m_ftw, m_pword, m_lfsr;
  bit               m_pend;
  bit               e_cv, e_av, e_busy, e_ready;
  int               e_ph, e_oct, e_aphi;
  bit               q_v[$];
  int               q_o[$];

  ddfs_ctrl #(.PHASE_W(PW), .OCT_W(OW), .CORE_LAT(CL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ftw_valid  (ftw_valid),
    .ftw_ready  (ftw_ready),
    .ftw_data   (ftw_data),
    .core_phase (core_phase),
    .core_valid (core_valid),
    .at_phi_r   (at_phi_r),
    .at_valid   (at_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Fold a phase value into (octant, core phase) from the definition.
  function automatic void fold(input longint unsigned a, input longint unsigned l,
                               output int o, output int p);
    longint unsigned v, rem;
    v = a;
`ifdef DDFS_DITHER_EN
    v = (a + (l % (64'd1 << DW))) % MOD;
`else
    v = v + (l & 64'd0);
`endif
    o   = int'(v >> (PW - 3));
    rem = (v >> DW) % (64'd1 << OW);
    p   = (o % 2 == 1) ? int'((64'd1 << OW) - 1 - rem) : int'(rem);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_drain_left = 0;
    m_acc = 0; m_ftw = 0; m_pword = 0; m_pend = 0; m_lfsr = 64'hACE1;
    e_cv = 0; e_ph = 0; e_oct = 0; e_av = 0; e_aphi = 0; e_busy = 0; e_ready = 1;
    q_v.delete(); q_o.delete();
    for (int i = 0; i < CL; i++) begin q_v.push_back(1'b0); q_o.push_back(0); end
  endtask

  // Advance the model by one clock given the inputs seen at that edge.
  task automatic model_step(input bit e, input bit v, input longint unsigned d);
    int o, p, nmode;
    bit wrap, acc_ok;
    longint unsigned sum;
    acc_ok = v && !m_pend;
    wrap = 1'b0;
    if (m_mode == M_RUN) begin
      fold(m_acc, m_lfsr, o, p);
      e_cv = 1'b1; e_ph = p; e_oct = o;
      sum = m_acc + m_ftw;
      wrap = (sum >= MOD);
      m_acc = sum % MOD;
      m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr % 2) == 1) ? 64'hB400 : 64'h0);
    end else begin
      e_cv = 1'b0;
    end
    e_av = q_v.pop_front();
    e_aphi = q_o.pop_front();
    q_v.push_back(e_cv);
    q_o.push_back(e_oct);
    case (m_mode)
      M_IDLE: nmode = e ? M_RUN : M_IDLE;
      M_RUN: begin
        nmode = e ? M_RUN : M_DRAIN;
        m_drain_left = CL;
      end
      default: begin
        if (e) nmode = M_RUN;
        else begin
          m_drain_left--;
          nmode = (m_drain_left == 0) ? M_IDLE : M_DRAIN;
        end
      end
    endcase
    if (m_mode == M_IDLE) begin
      if (m_pend) begin m_ftw = m_pword; m_pend = 1'b0; end
      else if (acc_ok) m_ftw = d;
    end else begin
      if (m_pend && (wrap || nmode == M_IDLE)) begin m_ftw = m_pword; m_pend = 1'b0; end
      if (acc_ok) begin m_pword = d; m_pend = 1'b1; end
    end
    m_mode  = nmode;
    e_busy  = (nmode != M_IDLE);
    e_ready = !m_pend;
  endtask

  task automatic check_all();
    check("busy", longint'(busy), longint'(e_busy));
    check("ftw_ready", longint'(ftw_ready), longint'(e_ready));
    check("core_valid", longint'(core_valid), longint'(e_cv));
    if (e_cv) check("core_phase", longint'(core_phase), longint'(e_ph));
    check("at_valid", longint'(at_valid), longint'(e_av));
    if (e_av) check("at_phi_r", longint'(at_phi_r), longint'(e_aphi));
  endtask

  task automatic cycle(input bit e, input bit v, input logic [PW-1:0] d);
    en = e; ftw_valid = v; ftw_data = d;
    model_step(e, v, longint'(d));
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; ftw_valid = 1'b0; ftw_data = '0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
  endtask

  int lit_oct1 [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int lit_ph1  [9] = '{0, 'hFFFF, 0, 'hFFFF, 0, 'hFFFF, 0, 'hFFFF, 0};
  int lit_ph2  [6] = '{0, 'h8000, 'hFFFF, 'h7FFF, 0, 'h8000};

  initial begin
    int ncv, nav, trail, stale;
    bit r_en, r_v;
    logic [PW-1:0] r_d;

    rst = 1'b1; en = 1'b0; ftw_valid = 1'b0; ftw_data = '0;
    do_reset();

    // Octant walk at 1/8 turn per sample, plus first at_valid latency.
    cycle(0, 1, 32'h2000_0000);
    cycle(0, 0, 0);
    ncv = 0; nav = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 0, 0);
      if (core_valid && ncv < 9) begin
`ifndef DDFS_DITHER_EN
        check("lit_phase_walk", longint'(core_phase), longint'(lit_ph1[ncv]));
`endif
        ncv++;
      end
      if (at_valid && nav < 9) begin
        if (nav == 0) check("first_at_latency", k - 1, CL + 1);
        check("lit_at_phi", longint'(at_phi_r), longint'(lit_oct1[nav]));
        nav++;
      end
    end
    check("lit_at_count", nav, 9);

    // Folding pins at 1/16 turn, then drain with trailing samples.
    do_reset();
    cycle(0, 1, 32'h1000_0000);
    cycle(0, 0, 0);
    ncv = 0;
    for (int k = 0; k < 7; k++) begin
      cycle(1, 0, 0);
      if (core_valid && ncv < 6) begin
`ifndef DDFS_DITHER_EN
        check("lit_fold", longint'(core_phase), longint'(lit_ph2[ncv]));
`endif
        ncv++;
      end
    end
    check("lit_fold_count", ncv, 6);
    trail = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0);
      if (!core_valid && at_valid) trail++;
    end
    check("trailing_at_valid", trail, CL);
    check("busy_after_drain", longint'(busy), 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0);

    // Word change while running waits for the wrap.
    do_reset();
    cycle(0, 1, 32'h4000_0000);
    cycle(0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(1, 0, 0);
    cycle(1, 1, 32'h1000_0000);
    check("ready_low_pending", longint'(ftw_ready), 0);
    for (int k = 0; k < 12; k++) cycle(1, 0, 0);

    // Reset mid-run flushes in-flight samples.
    for (int k = 0; k < 3; k++) cycle(1, 0, 0);
    do_reset();
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0);
      if (at_valid) stale++;
    end
    check("no_stale_at_valid", stale, 0);

    // Zero tuning word: acc frozen, pending word waits for IDLE entry.
    cycle(0, 1, 0);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0);
    cycle(1, 1, 32'h3000_0000);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0);
    for (int k = 0; k < 8; k++) cycle(0, 0, 0);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0);

    // Randomized traffic.
    r_en = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      if ($urandom_range(0, 9) == 0) r_en = !r_en;
      r_v = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       r_d = $urandom();
        1:       r_d = 32'h4000_0000 | $urandom();
        2:       r_d = '0;
        default: r_d = $urandom_range(0, 32'h00FF_FFFF);
      endcase
      cycle(r_en, r_v, r_d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
